// File: rtl/fpu_sched_pkg.sv
// fpu_sched_pkg: shared FPU types, scheduler state encoding and NaN constants.
// Rev 1.0
`default_nettype none

`ifndef FP16_NAN
`define FP16_NAN 16'h7E00
`endif
`ifndef FP32_NAN
`define FP32_NAN 32'h7FC0_0000
`endif
`ifndef FP64_NAN
`define FP64_NAN 64'h7FF8_0000_0000_0000
`endif

package fpu_sched_pkg;

  typedef logic [15:0] fp16_t;
  typedef logic [3:0]  condCode_t;
  typedef logic [4:0]  statusFlag_t;

  typedef enum logic [2:0] {
    FPU_ADD  = 3'd0,
    FPU_SUB  = 3'd1,
    FPU_MUL  = 3'd2,
    FPU_DIV  = 3'd3,
    FPU_SQRT = 3'd4,
    FPU_FMA  = 3'd5
  } fpuOp_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } fpuSchedState_t;

  localparam int FPU_SCHED_TIMEOUT = 64;

  // Quiet NaN for an IEEE format of the given width; all-ones is a NaN in any other format.
  function automatic logic [63:0] fp_qnan(input int w);
    if (w == 16) return {48'd0, `FP16_NAN};
    if (w == 32) return {32'd0, `FP32_NAN};
    if (w == 64) return `FP64_NAN;
    return '1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fpu_rr_arbiter.sv
// fpu_rr_arbiter: combinational round-robin grant starting at ptr_i, wrapping at NREQ.
// Rev 1.0
`default_nettype none

module fpu_rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] reqValid_i,
  input  logic [IDW-1:0]  ptr_i,
  output logic [NREQ-1:0] grant_o,
  output logic [IDW-1:0]  grantIdx_o,
  output logic            anyValid_o
);

  localparam int XW = IDW + 1;

  logic [XW-1:0] idx;
  logic          found;

  always_comb begin
    grant_o    = '0;
    grantIdx_o = '0;
    anyValid_o = 1'b0;
    found      = 1'b0;
    idx        = '0;
    for (int i = 0; i < NREQ; i++) begin
      // One extra bit so ptr+i cannot overflow before the explicit wrap.
      idx = {1'b0, ptr_i} + XW'(i);
      if (idx >= XW'(NREQ)) idx = idx - XW'(NREQ);
      if (!found && reqValid_i[idx[IDW-1:0]]) begin
        found                     = 1'b1;
        anyValid_o                = 1'b1;
        grant_o[idx[IDW-1:0]]     = 1'b1;
        grantIdx_o                = idx[IDW-1:0];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/fpu_sched.sv
// fpu_sched: round-robin scheduler sharing one fpu among NREQ requesters, one op in flight.
// Rev 1.0
`default_nettype none

module fpu_sched
  import fpu_sched_pkg::*;
#(
  parameter type FP_T    = fp16_t,
  parameter int  NREQ    = 4,
  parameter int  TIMEOUT = FPU_SCHED_TIMEOUT,
  parameter int  IDW     = $clog2(NREQ)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [NREQ-1:0] reqValid,
  output logic [NREQ-1:0] reqReady,
  input  FP_T             reqIn1 [NREQ],
  input  FP_T             reqIn2 [NREQ],
  input  FP_T             reqIn3 [NREQ],
  input  fpuOp_t          reqOp  [NREQ],
  output logic            rspValid,
  input  logic            rspReady,
  output logic [IDW-1:0]  rspId,
  output FP_T             rspOut,
  output condCode_t       rspCondCodes,
  output statusFlag_t     rspStatusFlags,
  output logic            rspTimeout,
  output FP_T             fpuIn1,
  output FP_T             fpuIn2,
  output FP_T             fpuIn3,
  output fpuOp_t          op,
  output logic            start,
  input  FP_T             fpuOut,
  input  logic            fpuDone,
  input  condCode_t       condCodes,
  input  statusFlag_t     statusFlags,
  output logic            busy
);

  localparam int  CW    = $clog2(TIMEOUT + 1);
  localparam FP_T NAN_C = FP_T'(fp_qnan($bits(FP_T)));

  fpuSchedState_t state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW-1:0] gnt_q, gnt_d;
  FP_T            in1_q, in1_d, in2_q, in2_d, in3_q, in3_d;
  fpuOp_t         op_q, op_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  FP_T            out_q, out_d;
  condCode_t      cc_q, cc_d;
  statusFlag_t    sf_q, sf_d;
  logic           to_q, to_d;

  logic [NREQ-1:0] arbGrant;
  logic [IDW-1:0]  arbIdx;
  logic            arbAny;

  fpu_rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .reqValid_i (reqValid),
    .ptr_i      (ptr_q),
    .grant_o    (arbGrant),
    .grantIdx_o (arbIdx),
    .anyValid_o (arbAny)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      in1_q   <= '0;
      in2_q   <= '0;
      in3_q   <= '0;
      op_q    <= FPU_ADD;
      cnt_q   <= '0;
      out_q   <= '0;
      cc_q    <= '0;
      sf_q    <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      in1_q   <= in1_d;
      in2_q   <= in2_d;
      in3_q   <= in3_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      cc_q    <= cc_d;
      sf_q    <= sf_d;
      to_q    <= to_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    in1_d   = in1_q;
    in2_d   = in2_q;
    in3_d   = in3_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    cc_d    = cc_q;
    sf_d    = sf_q;
    to_d    = to_q;
    case (state_q)
      IDLE: begin
        if (arbAny) begin
          gnt_d   = arbIdx;
          in1_d   = reqIn1[arbIdx];
          in2_d   = reqIn2[arbIdx];
          in3_d   = reqIn3[arbIdx];
          op_d    = reqOp[arbIdx];
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // Done has priority over the watchdog on the final allowed cycle.
        if (fpuDone) begin
          out_d   = fpuOut;
          cc_d    = condCodes;
          sf_d    = statusFlags;
          to_d    = 1'b0;
          state_d = RESP;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          out_d   = NAN_C;
          cc_d    = '0;
          sf_d    = '0;
          to_d    = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RESP: begin
        if (rspReady) begin
          ptr_d   = (gnt_q == IDW'(NREQ - 1)) ? '0 : gnt_q + IDW'(1);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign reqReady       = (state_q == IDLE) ? arbGrant : '0;
  assign start          = (state_q == ISSUE);
  assign rspValid       = (state_q == RESP);
  assign busy           = (state_q != IDLE);
  assign rspId          = gnt_q;
  assign rspOut         = out_q;
  assign rspCondCodes   = cc_q;
  assign rspStatusFlags = sf_q;
  assign rspTimeout     = to_q;
  assign fpuIn1         = in1_q;
  assign fpuIn2         = in2_q;
  assign fpuIn3         = in3_q;
  assign op             = op_q;

endmodule

`default_nettype wire
